// File: rtl/sseg_pkg.sv
// ------------------------------------------------------------------------
// sseg_pkg : segment codes, conversion FSM states and helpers.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

  localparam int SEG_DP_BIT = 7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low patterns for 0..9; bit 7 (dp) is off in every entry.
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Decimal digits needed to hold 2^w - 1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGIT[d];
    return SEG_DASH;
  endfunction

  function automatic logic [7:0] seg_pattern(input logic [3:0] d,
                                             input logic       ovf,
                                             input logic       blank,
                                             input logic       dp_on);
    logic [7:0] p;
    if (ovf)        p = SEG_DASH;
    else if (blank) p = SEG_BLANK;
    else            p = seg_encode(d);
    if (dp_on) p[SEG_DP_BIT] = 1'b0;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_bin2bcd.sv
// ------------------------------------------------------------------------
// sseg_bin2bcd : sequential double-dabble converter, one bit per cycle.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sseg_bin2bcd
  import sseg_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int NBCD = bcd_digits(BIN_W);
  localparam int SD   = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int CW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_t           state;
  logic [4*SD-1:0]       bcd_r;
  logic [BIN_W-1:0]      bin_r;
  logic [CW-1:0]         step;

  logic [4*SD-1:0]       adj;
  logic [4*SD+BIN_W-1:0] sh;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < SD; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_r} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd_r <= '0;
      bin_r <= '0;
      step  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_r <= bin;
            bcd_r <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_r <= sh[4*SD+BIN_W-1:BIN_W];
          bin_r <= sh[BIN_W-1:0];
          step  <= step + CW'(1);
          if (step == CW'(BIN_W-1)) begin
            done  <= 1'b1;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd = bcd_r[4*DIGITS-1:0];

  // Any nonzero digit beyond the displayable ones means value >= 10^DIGITS.
  if (SD > DIGITS) begin : g_ovf
    assign ovf = |bcd_r[4*SD-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/sseg_mux_driver.sv
// ------------------------------------------------------------------------
// sseg_mux_driver : binary-to-7-segment multiplexed display driver.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 12500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  number,
  input  logic              load,
  input  logic [DIGITS-1:0] dp,
  input  logic              blank_lz,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [7:0]        sseg_o,
  output logic [DIGITS-1:0] anodes_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic                  conv_busy;
  logic                  conv_done;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic                  conv_ovf;

  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_blank;
  logic [DIGITS-1:0]     blank_mask;
  logic                  zero_above;

  logic [4*DIGITS-1:0]   disp_bcd;
  logic [DIGITS-1:0]     disp_dp;
  logic [DIGITS-1:0]     disp_blank;
  logic                  disp_ovf;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  wrap;
  logic                  active;
  logic [7:0]            pat [DIGITS];

  sseg_bin2bcd #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .bin   (number),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  assign busy_o = conv_busy;
  assign ovf_o  = disp_ovf;

  // Attributes travel with the conversion so the commit is atomic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_dp    <= '0;
      pend_blank <= 1'b0;
    end else if (load && !conv_busy) begin
      pend_dp    <= dp;
      pend_blank <= blank_lz;
    end
  end

  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (conv_bcd[4*i +: 4] == 4'd0);
      blank_mask[i] = pend_blank & zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_bcd   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      disp_ovf   <= 1'b0;
    end else if (conv_done) begin
      disp_bcd   <= conv_bcd;
      disp_dp    <= pend_dp;
      disp_blank <= blank_mask;
      disp_ovf   <= conv_ovf;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    assign pat[g] = seg_pattern(disp_bcd[4*g +: 4], disp_ovf, disp_blank[g], disp_dp[g]);
  end

  always_comb begin
    wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
    if (!wrap)                          idx_nxt = idx;
    else if (idx == IDX_W'(DIGITS - 1)) idx_nxt = '0;
    else                                idx_nxt = idx + IDX_W'(1);
  end

  // Segments refresh every cycle so a commit shows up without disturbing the scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      active   <= 1'b0;
      sseg_o   <= SEG_BLANK;
      anodes_o <= '1;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      idx <= idx_nxt;
      if (wrap) active <= 1'b1;
      if (active || wrap) begin
        sseg_o   <= pat[idx_nxt];
        anodes_o <= ~(DIGITS'(1) << idx_nxt);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/sseg_mux_driver.md
SSEG_MUX_DRIVER -- requirements
Module: sseg_mux_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 SHALL have parameter BIN_W, default 14: width of the binary input.
REQ-003 SHALL have parameter REFRESH_DIV, default 12500: clk cycles per digit slot, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port number, input, BIN_W bits: unsigned binary value to display.
REQ-007 SHALL have port load, input, 1 bit: single-cycle strobe that starts a conversion.
REQ-008 SHALL have port dp, input, DIGITS bits: decimal-point enable per digit, active-high, sampled at load.
REQ-009 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled at load.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a conversion runs.
REQ-011 SHALL have port ovf_o, output, 1 bit: high when the last loaded value is at least 10^DIGITS.
REQ-012 SHALL have port sseg_o, output, 8 bits: active-low segments; bit 7 is dp, bits 6..0 are g..a.
REQ-013 SHALL have port anodes_o, output, DIGITS bits: active-low one-hot digit enable; bit 0 is the rightmost digit.

Function
REQ-014 SHALL implement a conversion FSM with states IDLE, CONV and COMMIT.
REQ-015 SHALL, on load=1 in IDLE, capture number, dp and blank_lz, set busy_o=1 and enter CONV.
REQ-016 SHALL ignore load while busy_o=1; no queueing and no restart.
REQ-017 SHALL perform double-dabble in CONV: one shift-and-add-3 step per cycle, BIN_W cycles.
REQ-018 SHALL, in COMMIT, atomically update the display register (BCD digits, dp, blank mask, ovf), clear busy_o and return to IDLE.
REQ-019 SHALL commit exactly BIN_W+1 cycles after the load cycle; the display register never shows partial results.
REQ-020 SHALL set ovf_o=1 if the value is at least 10^DIGITS; every digit then shows a dash (8'hBF, dp still applied).
REQ-021 SHALL, when blank_lz=1, blank zero digits above the most significant nonzero digit to 8'hFF (dp still applied); digit 0 is never blanked.
REQ-022 SHALL encode digits active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, bit 7 = 1); dp clears bit 7.
REQ-023 SHALL use a refresh counter running 0..REFRESH_DIV-1 that wraps to 0; each wrap advances the digit index, which wraps from DIGITS-1 to 0.
REQ-024 SHALL register sseg_o and anodes_o, changing in the same cycle; exactly one anodes_o bit is low after the first wrap.
REQ-025 SHALL let a commit change only the segment pattern from the next cycle; scan timing is unaffected.
REQ-026 SHALL handle DIGITS=1 with the index fixed at 0 and anodes_o=1'b0 after the first wrap.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, force: sseg_o=8'hFF, anodes_o all ones, busy_o=0, ovf_o=0, FSM=IDLE, refresh counter=0, digit index=0, display register=all-zero BCD with no dp and no blanking.
REQ-028 SHALL, if reset is asserted mid-conversion, abandon the conversion with no commit.
REQ-029 SHALL drop a load coincident with rst_n=0.

Structure
REQ-030 SHALL place in shared package sseg_pkg: the segment encodings for 0-9, SEG_BLANK (8'hFF), SEG_DASH (8'hBF) and the DP bit index.
REQ-031 SHALL implement the conversion FSM as sub-module sseg_bin2bcd, with ports clk, rst_n, start, bin, busy, done, bcd and ovf.
REQ-032 SHALL keep the scan counter, digit mux and encoder in the top level.

Verification (DIGITS=4, BIN_W=14, REFRESH_DIV=4)
REQ-033 SHALL test: load number=1234, blank_lz=0 -> busy_o high for 15 cycles; then per slot anodes_o 1110/1101/1011/0111 with sseg_o 99/B0/A4/F9.
REQ-034 SHALL test: load 7, blank_lz=1, dp=4'b0100 -> digit0=F8, digit1=FF, digit2=7F, digit3=FF.
REQ-035 SHALL test: load 10000 -> ovf_o=1 and all digits BF; then load 0, blank_lz=1 -> ovf_o=0, digit0=C0, others FF.
REQ-036 SHALL test: load 5678 then load 1111 three cycles later -> second load ignored; display 5678.
REQ-037 SHALL test: rst_n=0 during CONV of 9999 -> outputs at reset values, no commit; after release the display shows 0000 (C0 on each digit).
REQ-038 SHALL test: free run for 40 cycles -> anodes_o changes every 4 cycles, always one-hot-low, wrapping 0111 -> 1110.
